// File: rtl/sprite_pkg.sv
// Shared sprite command types and queue sizing for the sprite render path.
package sprite_pkg;

    typedef struct packed {
        logic [7:0]  id;
        logic [15:0] x;
        logic [15:0] y;
        logic [7:0]  scale;
    } sprite_cmd_t;

    localparam int SPRITE_QUEUE_DEPTH = 64;

endpackage

// File: rtl/sprite_queue_mem.sv
// Sprite command storage: one synchronous write port, one asynchronous read port, no reset.
module sprite_queue_mem
    import sprite_pkg::*;
#(
    parameter int DEPTH = SPRITE_QUEUE_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  sprite_cmd_t       wr_data,
    input  logic [AW-1:0]     rd_addr,
    output sprite_cmd_t       rd_data
);

    sprite_cmd_t mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sprite_queue.sv
// Per-frame sprite draw queue with first-word-fall-through head for the distributor.
module sprite_queue
    import sprite_pkg::*;
#(
    parameter int DEPTH = SPRITE_QUEUE_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clock,
    input  logic          fb_resetting,
    input  logic          enq_valid,
    input  logic [7:0]    enq_sprite_id,
    input  logic [15:0]   enq_sprite_x,
    input  logic [15:0]   enq_sprite_y,
    input  logic [7:0]    enq_sprite_scale,
    output logic          enq_ready,
    input  logic          sprite_queue_dequeue,
    output logic          sprite_queue_is_empty,
    output logic [7:0]    sprite_queue_sprite_id,
    output logic [15:0]   sprite_queue_sprite_x,
    output logic [15:0]   sprite_queue_sprite_y,
    output logic [7:0]    sprite_queue_sprite_scale,
    output logic [AW:0]   count,
    output logic          overflow
);

    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         empty;
    logic         full;
    logic         pop_acc;
    logic         push_acc;
    sprite_cmd_t  enq_cmd;
    sprite_cmd_t  head_cmd;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    // A pop on a full queue frees the slot the same-cycle push writes into.
    assign pop_acc  = sprite_queue_dequeue && !empty;
    assign push_acc = enq_valid && (!full || pop_acc);

    assign enq_cmd = '{id: enq_sprite_id, x: enq_sprite_x, y: enq_sprite_y, scale: enq_sprite_scale};

    always_ff @(posedge clock or posedge fb_resetting) begin
        if (fb_resetting) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (enq_valid && !push_acc) begin
                overflow <= 1'b1;
            end
        end
    end

    sprite_queue_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clock   (clock),
        .wr_en   (push_acc && !fb_resetting),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (enq_cmd),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_data (head_cmd)
    );

    assign enq_ready             = !full;
    assign sprite_queue_is_empty = empty;
    assign count                 = wr_ptr - rd_ptr;

    // Head reads as zero while empty so reset and drained states show a clean bus.
    assign sprite_queue_sprite_id    = empty ? '0 : head_cmd.id;
    assign sprite_queue_sprite_x     = empty ? '0 : head_cmd.x;
    assign sprite_queue_sprite_y     = empty ? '0 : head_cmd.y;
    assign sprite_queue_sprite_scale = empty ? '0 : head_cmd.scale;

endmodule

// File: doc/sprite_queue.md
# sprite_queue

Per-frame sprite draw queue feeding `sprite_distributor`. The host side pushes draw commands (id, x, y, scale) for the coming frame. The render side pops them through a first-word-fall-through `is_empty`/`dequeue` interface matching the distributor's one-cycle dequeue pulse. `fb_resetting` clears the queue at every frame-buffer reset, so each frame's draw list starts empty.

## Interface
- `DEPTH`, default 64: entries; power of two, ≥ 4.
- `AW`, default $clog2(DEPTH): pointer width, derived, not overridden.
- `clock`  in  1: system clock.
- `fb_resetting`  in  1: reset, asynchronous, active-high; clears queue.
- `enq_valid`  in  1: host push request, sampled on rising edge.
- `enq_sprite_id`  in  8: sprite id to draw.
- `enq_sprite_x`, `enq_sprite_y`  in  16 each: screen position.
- `enq_sprite_scale`  in  8: scale factor.
- `enq_ready`  out  1: not full; reset 1.
- `sprite_queue_dequeue`  in  1: pop head, from distributor.
- `sprite_queue_is_empty`  out  1: reset 1.
- `sprite_queue_sprite_id`  out  8: head entry id; reset 0.
- `sprite_queue_sprite_x`, `sprite_queue_sprite_y`  out  16 each: head position; reset 0.
- `sprite_queue_sprite_scale`  out  8: head scale; reset 0.
- `count`  out  AW+1: occupancy 0..DEPTH; reset 0.
- `overflow`  out  1: sticky, set on dropped push; reset 0, cleared only by `fb_resetting`.

## Operation
- Circular buffer: `wr_ptr`, `rd_ptr` of AW+1 bits each. The MSB is the wrap bit. Empty when the pointers are equal. Full when the low AW bits are equal and the MSBs differ.
- Push accepted when `enq_valid && (!full || pop_accepted)`. The entry is written at `wr_ptr[AW-1:0]` and `wr_ptr` increments.
- Pop accepted when `sprite_queue_dequeue && !empty`. `rd_ptr` increments. A dequeue while empty is ignored; no underflow flag.
- Push while full with no accepted pop: entry dropped, `overflow` set, pointers unchanged.
- Simultaneous push and pop:
  - Both take effect and `count` is unchanged.
  - On empty, only the push takes effect, because the pop is ignored.
  - On full, both take effect; the push writes the slot freed by the pop.
- Head outputs are first-word fall-through: they always show `mem[rd_ptr]` when non-empty. When empty the value is don't-care; the bench checks it only when `is_empty`=0.
- `count = wr_ptr - rd_ptr`, modulo 2^(AW+1).
- Asserting `fb_resetting`, at any time including mid-push or mid-pop, immediately zeroes the pointers, `count` and `overflow`. Storage contents are not cleared. While `fb_resetting` is held, pushes and pops are ignored.

## Timing
- Push at edge N: `is_empty` falls and head is valid in cycle N+1, giving one-cycle write-to-read latency.
- Pop at edge N: the next head (or `is_empty`=1) is visible in cycle N+1. This matches the distributor, which pulses dequeue for one cycle and re-samples two cycles later.
- `enq_ready`, `is_empty`, `count` and `overflow` are registered or decoded from registered pointers only; no combinational path from `enq_valid`/`dequeue` to them.
- Head data is an asynchronous read of distributed RAM, addressed by registered `rd_ptr`. No combinational path exists from the `dequeue` input to the head outputs.
- Sustained throughput: one push and one pop per cycle.

## Structure
- Shared package `sprite_pkg` holds:
  - `sprite_cmd_t`, a packed struct {id[7:0], x[15:0], y[15:0], scale[7:0]}, 48 bits.
  - `SPRITE_QUEUE_DEPTH`.
- Sub-module `sprite_queue_mem`: DEPTH×48 distributed RAM with one synchronous write port and one asynchronous read port, no reset. The top level holds the pointers, flags and count.

## Test plan
- Reset, then 3 pushes {id=1,x=10,y=20,s=64}, {2,…}, {3,…} -> `count`=3. Head id=1 one cycle after the first push. Three distributor-style pops yield ids 1, 2, 3, then `is_empty`=1.
- Fill all 64 entries, then push a 65th -> `enq_ready`=0, `overflow`=1, `count`=64. Draining 64 entries returns the first 64 in order.
- On a full queue, push and pop in the same cycle -> `count` stays 64, `overflow` stays 0. The new entry appears last in the drain order.
- On an empty queue, push and dequeue in the same cycle -> the pop is ignored, `count`=1, and head equals the pushed entry.
- Wrap-around: over 200 cycles of random push/pop (occupancy kept <64) -> data matches a scoreboard model and `count` always equals the model.
- With 10 entries queued, assert `fb_resetting` asynchronously between edges for 3 cycles -> `is_empty`=1, `count`=0, `overflow`=0 immediately. A push after release is read back first.
